instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Parametrised successor to the single-cycle PC / PC-adder / instruction-memory path.
//  Owns the program counter and issues sequential fetches to a synchronous
//  instruction memory. Buffers returned words with their PCs in an instruction queue.
//  Hands instructions to decode/control over a valid/ready handshake.
//  Accepts branch/jump redirects and flushes all wrong-path work.
// PARAMETERS
//  ADDR_W    32  PC / memory address width
//  DATA_W    32  instruction width; PC step = DATA_W/8 bytes
//  DEPTH     4   instruction-queue entries; power of 2, >=2
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       synchronous reset, active low
//  imem_req     out  1       read request to instruction memory this cycle
//  imem_addr    out  ADDR_W  byte address of request (= current PC)
//  imem_rdata   in   DATA_W  read data, valid exactly 1 cycle after imem_req
//  redir_valid  in   1       branch/jump taken: redirect fetch
//  redir_pc     in   ADDR_W  redirect target; low log2(DATA_W/8) bits ignored (forced 0)
//  if_valid     out  1       queue head holds a valid instruction
//  if_ready     in   1       decode accepts head this cycle
//  if_instr     out  DATA_W  head instruction
//  if_pc        out  ADDR_W  PC of head instruction
//  if_count     out  log2(DEPTH)+1  queue occupancy
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): pc=RESET_PC, queue empty, inflight=0.
//    Outputs then: imem_req=0, if_valid=0, if_count=0. if_instr/if_pc are don't-care.
//    Reset overrides redirect, handshake and in-flight data. A response due the cycle after reset is dropped.
//  - Issue: imem_req = rst_n & ~redir_valid & (count + inflight < DEPTH).
//    imem_addr = pc. On issue, pc <= pc + DATA_W/8, wrapping modulo 2^ADDR_W.
//    The issued PC is held in a one-deep inflight register (inflight=1).
//  - Response: the cycle after an issue, {imem_rdata, inflight_pc} is written to the queue tail unless killed.
//    Sustained throughput is 1 instruction/cycle.
//  - Latency: request at cycle t, data captured at t+1 edge, if_valid=1 from t+2 (registered queue, no bypass).
//  - Handshake: a pop occurs when if_valid & if_ready. if_instr/if_pc stay stable while if_valid & ~if_ready.
//    Push and pop may occur in the same cycle with count unchanged.
//  - Full: the credit rule (count + inflight < DEPTH) guarantees no push into a full queue.
//    No data is ever dropped on a stall.
//  - Empty: if_valid=0; if_ready is ignored.
//  - Redirect at cycle t:
//    * pc <= redir_pc (aligned); queue flushed, so if_valid=0 and count=0 at t+1.
//    * A response arriving at t+1 for a pre-redirect request is discarded. A pop at t is also void.
//    * imem_req=0 in cycle t; first target fetch issues at t+1; target instruction visible at t+3.
//    * Back-to-back redirects: the last one wins.
//  - PC arithmetic is unsigned; no misalign or overflow flags are produced.
// STRUCTURE
//  - Package fetch_pkg holds:
//    * PC_STEP = DATA_W/8 and ALIGN_BITS = $clog2(PC_STEP);
//    * typedef fetch_entry_t {pc, instr};
//    * function align_pc().
//  - Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, DEPTH entries.
//    Ports: push, pop, flush, count. Flush has priority over push and pop.
//  - Top level holds: pc register, inflight valid/pc, kill bit, credit logic.
// TESTING
//  - Reset: hold rst_n=0 for 2 cycles, release -> imem_req=1, imem_addr=0x0 in first cycle.
//    if_valid=1, if_pc=0x0 two cycles later.
//  - Stream: if_ready=1, memory returns addr+0x100 as data.
//    -> if_pc 0x0,0x4,0x8,... one per cycle; if_instr=if_pc+0x100.
//  - Stall: if_ready=0 from reset.
//    -> exactly 4 requests (0x0..0xC), then imem_req=0; if_count=4.
//    -> head stays pc=0x0; raising if_ready drains in order, fetch resumes at 0x10.
//  - Redirect: redir_valid=1, redir_pc=0x403 while streaming at pc 0x20.
//    -> imem_req=0 that cycle; if_valid=0 next cycle; next imem_addr=0x400.
//    -> no instruction with pc 0x1C/0x20 ever accepted; next if_pc=0x400.
//  - Redirect during stall with full queue and an outstanding response -> queue empty, stale response dropped.
//  - Wrap: RESET_PC=0xFFFFFFF8 -> fetch addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
//  - Reset mid-stream with inflight=1 -> if_valid=0 and if_count=0 after reset; stale data never appears.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_pkg : shared widths, queue entry type and PC alignment helper for     |
// |             the instruction fetch unit.                                     |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;
  localparam int PC_STEP      = FETCH_DATA_W / 8;
  localparam int ALIGN_BITS   = $clog2(PC_STEP);

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  // Width-agnostic: callers widen to 64 bits and truncate the result back.
  function automatic logic [63:0] align_pc(input logic [63:0] pc, input int align_bits);
    return pc & ~((64'd1 << align_bits) - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue : synchronous FIFO of fetched {pc, instr} entries; flush wins   |
// |               over push and pop, head is read straight from storage.        |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_pop;
  logic               w_do_push;

  assign valid     = (r_count != '0);
  assign w_do_pop  = pop & valid;
  assign w_do_push = push & ((r_count != CNT_W'(DEPTH)) | w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_fetch_unit : PC owner issuing sequential reads to a 1-cycle          |
// |                    synchronous instruction memory, with redirect flush.    |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [DATA_W-1:0]      imem_rdata,
  input  logic                   redir_valid,
  input  logic [ADDR_W-1:0]      redir_pc,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [DATA_W-1:0]      if_instr,
  output logic [ADDR_W-1:0]      if_pc,
  output logic [$clog2(DEPTH):0] if_count
);

  localparam int STEP  = DATA_W / 8;
  localparam int ALIGN = $clog2(STEP);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_W > 64) begin : g_param_check
    $error("instr_fetch_unit: DEPTH must be a power of 2 >= 2 and ADDR_W <= 64");
  end

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_infl_pc;
  logic              r_infl;
  logic              r_kill;
  logic [ADDR_W-1:0] w_redir_pc;
  logic              w_credit;
  logic              w_push;
  logic              w_pop;
  entry_t            w_push_data;
  entry_t            w_head;

  // Occupancy plus the outstanding response must leave room, so a push never hits a full queue.
  assign w_credit   = (32'(if_count) + 32'(r_infl)) < 32'(DEPTH);
  assign imem_req   = rst_n & ~redir_valid & w_credit;
  assign imem_addr  = r_pc;
  assign w_redir_pc = ADDR_W'(align_pc(64'(redir_pc), ALIGN));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_infl    <= 1'b0;
      r_infl_pc <= '0;
      r_kill    <= 1'b0;
    end else begin
      r_kill <= redir_valid;
      r_infl <= imem_req;
      if (imem_req) r_infl_pc <= r_pc;
      if (redir_valid)   r_pc <= w_redir_pc;
      else if (imem_req) r_pc <= r_pc + ADDR_W'(STEP);
    end
  end

  // A response landing the cycle after a redirect belongs to the wrong path.
  assign w_push            = r_infl & ~r_kill;
  assign w_push_data.pc    = r_infl_pc;
  assign w_push_data.instr = imem_rdata;
  assign w_pop             = if_valid & if_ready;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redir_valid),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .valid     (if_valid),
    .count     (if_count)
  );

  assign if_instr = w_head.instr;
  assign if_pc    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_fetch_unit : directed bench with a queue-level reference model.   |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata = '0;
  logic          redir_valid = 1'b0;
  logic [AW-1:0] redir_pc = '0;
  logic          if_valid;
  logic          if_ready = 1'b0;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic [CW-1:0] if_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_count    (if_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Instruction memory: data = address + 0x100, valid the cycle after the request.
  logic          mem_pend = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  always @(negedge clk) begin
    mem_pend = imem_req;
    mem_addr = imem_addr;
  end
  always @(posedge clk) begin
    #1;
    imem_rdata = (mem_pend === 1'b1) ? mem_addr + 32'h100 : 32'hDEAD_BEEF;
  end

  // Reference model: an ordered queue of fetched entries plus one outstanding request.
  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_pc = '0;
  logic [AW-1:0] m_ipc = '0;
  bit            m_infl = 1'b0;
  bit            m_known = 1'b0;
  bit            e_req;
  int            cyc = 0;
  logic [AW-1:0] amask;

  logic [AW-1:0] iss_q[$];
  int            iss_c[$];
  logic [AW-1:0] acc_q[$];
  logic [DW-1:0] acc_i[$];
  int            acc_c[$];

  always @(negedge clk) begin
    cyc++;
    amask = AW'((1 << ALIGN_BITS) - 1);
    if (m_known) begin
      e_req = rst_n && !redir_valid && ((mq.size() + int'(m_infl)) < DEPTH);
      chk("imem_req", 64'(imem_req), 64'(e_req));
      if (e_req) chk("imem_addr", 64'(imem_addr), 64'(m_pc));
      chk("if_valid", 64'(if_valid), 64'(mq.size() != 0));
      chk("if_count", 64'(if_count), 64'(mq.size()));
      if (mq.size() != 0) begin
        chk("if_pc", 64'(if_pc), 64'(mq[0].pc));
        chk("if_instr", 64'(if_instr), 64'(mq[0].instr));
      end
      if (imem_req === 1'b1) begin
        iss_q.push_back(imem_addr);
        iss_c.push_back(cyc);
      end
      if (rst_n && !redir_valid && if_valid === 1'b1 && if_ready) begin
        acc_q.push_back(if_pc);
        acc_i.push_back(if_instr);
        acc_c.push_back(cyc);
      end
      if (rst_n) begin
        if (redir_valid) begin
          mq.delete();
          m_infl = 1'b0;
          m_pc   = redir_pc & ~amask;
        end else begin
          if (mq.size() != 0 && if_ready) void'(mq.pop_front());
          if (m_infl) mq.push_back('{pc: m_ipc, instr: m_ipc + 32'h100});
          m_infl = e_req;
          if (e_req) begin
            m_ipc = m_pc;
            m_pc  = m_pc + AW'(PC_STEP);
          end
        end
      end
    end
    if (!rst_n) begin
      mq.delete();
      m_pc    = '0;
      m_infl  = 1'b0;
      m_known = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_q.delete(); iss_c.delete();
    acc_q.delete(); acc_i.delete(); acc_c.delete();
  endtask

  function automatic int count_acc(input logic [AW-1:0] pc);
    int n = 0;
    foreach (acc_q[i]) if (acc_q[i] == pc) n++;
    return n;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then stream with decode always ready
    rst_n = 1'b0; if_ready = 1'b1;
    tick(1);
    @(negedge clk);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_count", 64'(if_count), 64'd0);
    tick(1);
    rst_n = 1'b1;
    clear_logs();
    @(negedge clk);
    chk("first_req", 64'(imem_req), 64'd1);
    chk("first_addr", 64'(imem_addr), 64'h0);
    tick(8);
    chk("pre_redir_addr", 64'(imem_addr), 64'h20);
    redir_valid = 1'b1; redir_pc = 32'h403;
    @(negedge clk);
    chk("redir_no_req", 64'(imem_req), 64'd0);
    tick(1);
    redir_valid = 1'b0;
    @(negedge clk);
    chk("redir_valid_drop", 64'(if_valid), 64'd0);
    chk("redir_next_addr", 64'(imem_addr), 64'h400);
    tick(6);
    chk("stream_acc0", 64'(acc_q[0]), 64'h0);
    chk("stream_acc1", 64'(acc_q[1]), 64'h4);
    chk("stream_instr2", 64'(acc_i[2]), 64'h108);
    chk("stream_latency", 64'(acc_c[0] - iss_c[0]), 64'd2);
    chk("stream_acc5", 64'(acc_q[5]), 64'h14);
    chk("redir_target_pc", 64'(acc_q[6]), 64'h400);
    chk("wrong_path", 64'(count_acc(32'h18) + count_acc(32'h1C) + count_acc(32'h20)), 64'd0);

    // Stall from reset: four requests fill the queue, then drain in order
    rst_n = 1'b0; if_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    clear_logs();
    tick(8);
    @(negedge clk);
    chk("stall_count", 64'(if_count), 64'd4);
    chk("stall_req", 64'(imem_req), 64'd0);
    chk("stall_head", 64'(if_pc), 64'h0);
    chk("stall_issued", 64'(iss_q.size()), 64'd4);
    chk("stall_last_addr", 64'(iss_q[3]), 64'hC);
    tick(1);
    if_ready = 1'b1;
    tick(10);
    chk("drain_acc0", 64'(acc_q[0]), 64'h0);
    chk("drain_acc3", 64'(acc_q[3]), 64'hC);
    chk("resume_addr", 64'(iss_q[4]), 64'h10);

    // Redirect while stalled with three queued and one response outstanding
    rst_n = 1'b0; if_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    clear_logs();
    tick(4);
    redir_valid = 1'b1; redir_pc = 32'h800;
    @(negedge clk);
    chk("flush_pre_count", 64'(if_count), 64'd3);
    tick(1);
    redir_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", 64'(if_count), 64'd0);
    chk("flush_addr", 64'(imem_addr), 64'h800);
    tick(1);
    @(negedge clk);
    chk("stale_dropped", 64'(if_count), 64'd0);
    tick(1);
    @(negedge clk);
    chk("flush_refill", 64'(if_pc), 64'h800);
    tick(1);
    if_ready = 1'b1;
    tick(4);
    chk("flush_acc0", 64'(acc_q[0]), 64'h800);

    // Address wrap through the top of the space
    redir_valid = 1'b1; redir_pc = 32'hFFFF_FFF9;
    tick(1);
    redir_valid = 1'b0;
    clear_logs();
    tick(6);
    chk("wrap0", 64'(iss_q[0]), 64'hFFFF_FFF8);
    chk("wrap1", 64'(iss_q[1]), 64'hFFFF_FFFC);
    chk("wrap2", 64'(iss_q[2]), 64'h0);
    chk("wrap3", 64'(iss_q[3]), 64'h4);

    // Reset mid-stream with a response outstanding
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1; if_ready = 1'b0;
    clear_logs();
    @(negedge clk);
    chk("midrst_count", 64'(if_count), 64'd0);
    chk("midrst_valid", 64'(if_valid), 64'd0);
    tick(1);
    @(negedge clk);
    chk("midrst_no_stale", 64'(if_count), 64'd0);
    tick(1);
    @(negedge clk);
    chk("midrst_head_pc", 64'(if_pc), 64'h0);
    chk("midrst_head_instr", 64'(if_instr), 64'h100);
    tick(1);
    if_ready = 1'b1;
    tick(3);
    chk("midrst_acc0", 64'(acc_q[0]), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
